lsu_mem_if: RTL and testbench

Load/store unit bridging the core's memory-control outputs (MemRead/MemWrite, 3-bit LoadStore_Sel, ALU-computed address, rs2 data) to a word-wide, byte-enabled data-memory bus with a req/ack handshake. It is the memory-side counterpart of the instruction decoder. It accepts one access at a time, splits misaligned accesses into two bus beats, and steers byte lanes. Load results are sign- or zero-extended and returned to writeback.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_align.sv | 53 +++++
 rtl/lsu_mem_if.sv | 168 ++++++++++++++++
 tb/tb_lsu_mem_if.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared LoadStore_Sel encodings, FSM state type and access-size helpers for the
// load/store unit and its lane-steering datapath.
package lsu_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b011;
    localparam logic [2:0] LS_HU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1,
        ST_RESP
    } lsu_state_e;

    // Unshifted byte-enable pattern of an access; reserved encodings behave as W.
    function automatic logic [3:0] size_mask(input logic [2:0] sel);
        case (sel)
            LS_B, LS_BU: size_mask = 4'b0001;
            LS_H, LS_HU: size_mask = 4'b0011;
            default:     size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] off);
        case (sel)
            LS_B, LS_BU: is_misaligned = 1'b0;
            LS_H, LS_HU: is_misaligned = (off == 2'd3);
            default:     is_misaligned = (off != 2'd0);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store rotate, per-beat byte enables, and load
// gather across up to two bus words followed by sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [1:0]  off,
    input  logic        second_beat,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_lo,
    input  logic [23:0] ld_hi,
    output logic [3:0]  be,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_data
);

    logic [7:0]  be_span;
    logic [31:0] gathered;

    always_comb begin
        // Upper nibble of the span holds the bytes that spill into the next word.
        be_span = {4'b0000, size_mask(sel)} << off;
        be      = second_beat ? be_span[7:4] : be_span[3:0];

        case (off)
            2'd0: begin
                st_lanes = st_data;
                gathered = ld_lo;
            end
            2'd1: begin
                st_lanes = {st_data[23:0], st_data[31:24]};
                gathered = {ld_hi[7:0], ld_lo[31:8]};
            end
            2'd2: begin
                st_lanes = {st_data[15:0], st_data[31:16]};
                gathered = {ld_hi[15:0], ld_lo[31:16]};
            end
            default: begin
                st_lanes = {st_data[7:0], st_data[31:8]};
                gathered = {ld_hi[23:0], ld_lo[31:24]};
            end
        endcase

        case (sel)
            LS_B:    ld_data = {{24{gathered[7]}}, gathered[7:0]};
            LS_H:    ld_data = {{16{gathered[15]}}, gathered[15:0]};
            LS_BU:   ld_data = {24'h000000, gathered[7:0]};
            LS_HU:   ld_data = {16'h0000, gathered[15:0]};
            default: ld_data = gathered;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit: one access at a time onto a word-wide byte-enabled req/ack bus.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned H/HU/W accesses into two beats.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_sel,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic              split_q, split_d;
    logic [31:0]       beat0_q, beat0_d;
`else
    logic              fault_q, fault_d;
`endif

    logic [ADDR_W-1:0] word_addr;
    logic              in_beat, in_beat1;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata, load_data, ld_lo;

    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_SPLIT_EN
    assign in_beat1  = (state_q == ST_BEAT1);
    assign ld_lo     = in_beat1 ? beat0_q : mem_rdata;
    assign rsp_fault = 1'b0;
`else
    assign in_beat1  = 1'b0;
    assign ld_lo     = mem_rdata;
    assign rsp_fault = rsp_valid && fault_q;
`endif
    assign in_beat = (state_q == ST_BEAT0) || in_beat1;

    lsu_align u_align (
        .sel         (sel_q),
        .off         (addr_q[1:0]),
        .second_beat (in_beat1),
        .st_data     (wdata_q),
        .ld_lo       (ld_lo),
        .ld_hi       (mem_rdata[23:0]),
        .be          (lane_be),
        .st_lanes    (lane_wdata),
        .ld_data     (load_data)
    );

    // Bus outputs derive only from latched request state, so they hold until ack.
    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign mem_req   = in_beat;
    assign mem_we    = in_beat && we_q;
    assign mem_addr  = !in_beat ? '0 : (in_beat1 ? word_addr + ADDR_W'(4) : word_addr);
    assign mem_be    = in_beat ? lane_be : 4'b0000;
    assign mem_wdata = in_beat ? lane_wdata : 32'h0;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_d = split_q;
        beat0_d = beat0_q;
`else
        fault_d = fault_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    sel_d   = req_sel;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    state_d = ST_BEAT0;
`ifdef LSU_MISALIGN_SPLIT_EN
                    split_d = is_misaligned(req_sel, req_addr[1:0]);
`else
                    fault_d = is_misaligned(req_sel, req_addr[1:0]);
                    if (fault_d) begin
                        state_d = ST_RESP;
                    end
`endif
                end
            end
            ST_BEAT0: begin
                if (mem_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    beat0_d = mem_rdata;
                    if (split_q) begin
                        state_d = ST_BEAT1;
                    end else begin
                        rdata_d = we_q ? 32'h0 : load_data;
                        state_d = ST_RESP;
                    end
`else
                    rdata_d = we_q ? 32'h0 : load_data;
                    state_d = ST_RESP;
`endif
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_BEAT1: begin
                if (mem_ack) begin
                    rdata_d = we_q ? 32'h0 : load_data;
                    state_d = ST_RESP;
                end
            end
`endif
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q <= 1'b0;
`else
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q <= split_d;
`else
            fault_q <= fault_d;
`endif
        end
        we_q    <= we_d;
        sel_q   <= sel_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
        beat0_q <= beat0_d;
`endif
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Scoreboard bench for lsu_mem_if: expected bus beats and responses are queued at
// issue time; a bus responder and a response monitor pop and compare.
module tb_lsu_mem_if;
    import lsu_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_sel = 3'b000;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'h0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack = 1'b0;
    logic [31:0]       mem_rdata = 32'h0;

    lsu_mem_if #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          acc;
    } rsp_t;

    beat_t       beat_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          beats_seen = 0;
    int          bus_waits = 0;
    int          waitcnt = 0;
    int          last_acc = 0;
    logic        bus_auto = 1'b1;
    logic        force_ack = 1'b0;
    logic        prev_rsp = 1'b0;
    beat_t       bb;
    rsp_t        re;
    logic [31:0] lane_mask;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus responder: acks each beat after bus_waits wait cycles, checking it against the queue.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (!bus_auto) begin
            mem_ack = force_ack;
        end else if (rst) begin
            waitcnt = 0;
        end else if (mem_req) begin
            if (waitcnt < bus_waits) begin
                waitcnt++;
            end else begin
                waitcnt = 0;
                beats_seen++;
                if (beat_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: mem_req=1 addr=0x%08h, expected no bus beat", mem_addr);
                end else begin
                    bb = beat_q.pop_front();
                    check32("beat_addr", mem_addr, bb.addr);
                    check32("beat_be", {28'h0, mem_be}, {28'h0, bb.be});
                    check32("beat_we", {31'h0, mem_we}, {31'h0, bb.we});
                    if (bb.we) begin
                        lane_mask = {{8{bb.be[3]}}, {8{bb.be[2]}}, {8{bb.be[1]}}, {8{bb.be[0]}}};
                        check32("beat_wdata", mem_wdata & lane_mask, bb.wdata & lane_mask);
                    end
                end
                mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                mem_ack = 1'b1;
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rst) begin
            prev_rsp = 1'b0;
        end else begin
            if (prev_rsp) check32("rsp_one_cycle", {31'h0, rsp_valid}, 32'h0);
            if (rsp_valid && !prev_rsp) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 rdata=0x%08h, expected no response", rsp_rdata);
                end else begin
                    re = rsp_q.pop_front();
                    check32("rsp_rdata", rsp_rdata, re.rdata);
                    check32("rsp_fault", {31'h0, rsp_fault}, {31'h0, re.fault});
                    if (re.lat >= 0) check32("rsp_latency", 32'(cyc - re.acc), 32'(re.lat));
                end
            end
            prev_rsp = rsp_valid;
        end
    end

    task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
        beat_t b;
        b.addr = a; b.be = be; b.we = we; b.wdata = wd;
        beat_q.push_back(b);
    endtask

    task automatic issue(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                         input logic [31:0] wd, input logic push, input logic [31:0] exp_rd,
                         input logic exp_fault, input int lat);
        int   n;
        rsp_t r;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: req_ready=0 after %0d cycles, expected 1", n);
        end else begin
            req_we = we; req_sel = sel; req_addr = addr; req_wdata = wd;
            req_valid = 1'b1;
            last_acc = cyc;
            if (push) begin
                r.rdata = exp_rd; r.fault = exp_fault; r.lat = lat; r.acc = cyc;
                rsp_q.push_back(r);
            end
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || beat_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rsp_q.size() != 0 || beat_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: pending rsp=%0d beats=%0d expected 0", rsp_q.size(), beat_q.size());
            rsp_q.delete();
            beat_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int acc1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("reset_mem_req", {31'h0, mem_req}, 32'h0);
        check32("reset_mem_we", {31'h0, mem_we}, 32'h0);
        check32("reset_mem_addr", mem_addr, 32'h0);
        check32("reset_mem_be", {28'h0, mem_be}, 32'h0);
        check32("reset_mem_wdata", mem_wdata, 32'h0);
        check32("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check32("reset_rsp_rdata", rsp_rdata, 32'h0);
        check32("reset_rsp_fault", {31'h0, rsp_fault}, 32'h0);
        check32("ready_in_reset", {31'h0, req_ready}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check32("ready_after_reset", {31'h0, req_ready}, 32'h1);

        // Aligned LW, zero wait
        mem[32'h100] = 32'hDEADBEEF;
        push_beat(32'h100, 4'b1111, 1'b0, 32'h0);
        issue(1'b0, LS_W, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 2);
        drain();

        // LB / LBU on lane 3
        mem[32'h100] = 32'h80000000;
        push_beat(32'h100, 4'b1000, 1'b0, 32'h0);
        issue(1'b0, LS_B, 32'h103, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0, 2);
        drain();
        push_beat(32'h100, 4'b1000, 1'b0, 32'h0);
        issue(1'b0, LS_BU, 32'h103, 32'h0, 1'b1, 32'h00000080, 1'b0, 2);
        drain();

        // SH at offset 2, SB at offset 1
        push_beat(32'h100, 4'b1100, 1'b1, 32'hABCD0000);
        issue(1'b1, LS_H, 32'h102, 32'h1234ABCD, 1'b1, 32'h0, 1'b0, 2);
        drain();
        push_beat(32'h100, 4'b0010, 1'b1, 32'h0000A500);
        issue(1'b1, LS_B, 32'h101, 32'h000000A5, 1'b1, 32'h0, 1'b0, 2);
        drain();

        // Wait states: LH with 2 waits, LHU with 1 wait
        mem[32'h100] = 32'h00008001;
        bus_waits = 2;
        push_beat(32'h100, 4'b0011, 1'b0, 32'h0);
        issue(1'b0, LS_H, 32'h100, 32'h0, 1'b1, 32'hFFFF8001, 1'b0, 4);
        drain();
        mem[32'h100] = 32'h80010000;
        bus_waits = 1;
        push_beat(32'h100, 4'b1100, 1'b0, 32'h0);
        issue(1'b0, LS_HU, 32'h102, 32'h0, 1'b1, 32'h00008001, 1'b0, 3);
        drain();
        bus_waits = 0;

        // Reserved encoding behaves as W
        mem[32'h104] = 32'h0BADF00D;
        push_beat(32'h104, 4'b1111, 1'b0, 32'h0);
        issue(1'b0, 3'b111, 32'h104, 32'h0, 1'b1, 32'h0BADF00D, 1'b0, 2);
        drain();

        // Back-to-back: second request accepted three cycles after the first
        mem[32'h100] = 32'h11112222;
        push_beat(32'h100, 4'b1111, 1'b0, 32'h0);
        push_beat(32'h100, 4'b1111, 1'b0, 32'h0);
        issue(1'b0, LS_W, 32'h100, 32'h0, 1'b1, 32'h11112222, 1'b0, 2);
        acc1 = last_acc;
        issue(1'b0, LS_W, 32'h100, 32'h0, 1'b1, 32'h11112222, 1'b0, 2);
        check32("b2b_accept_gap", 32'(last_acc - acc1), 32'd3);
        drain();

        // Misaligned accesses
        mem[32'h100] = 32'h44332211;
        mem[32'h104] = 32'h88776655;
        b0 = beats_seen;
`ifdef LSU_MISALIGN_SPLIT_EN
        push_beat(32'h100, 4'b1110, 1'b0, 32'h0);
        push_beat(32'h104, 4'b0001, 1'b0, 32'h0);
        issue(1'b0, LS_W, 32'h101, 32'h0, 1'b1, 32'h55443322, 1'b0, 3);
        drain();
        check32("split_beat_count", 32'(beats_seen - b0), 32'd2);
        push_beat(32'hFFFFFFFC, 4'b1100, 1'b1, 32'hC3D40000);
        push_beat(32'h00000000, 4'b0011, 1'b1, 32'h0000A1B2);
        issue(1'b1, LS_W, 32'hFFFFFFFE, 32'hA1B2C3D4, 1'b1, 32'h0, 1'b0, 3);
        drain();
        mem[32'h100] = 32'hFE000000;
        mem[32'h104] = 32'h000000FF;
        bus_waits = 1;
        push_beat(32'h100, 4'b1000, 1'b0, 32'h0);
        push_beat(32'h104, 4'b0001, 1'b0, 32'h0);
        issue(1'b0, LS_H, 32'h103, 32'h0, 1'b1, 32'hFFFFFFFE, 1'b0, 5);
        drain();
        bus_waits = 0;
`else
        issue(1'b0, LS_W, 32'h101, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        drain();
        issue(1'b1, LS_W, 32'hFFFFFFFE, 32'hA1B2C3D4, 1'b1, 32'h0, 1'b1, 1);
        drain();
        issue(1'b0, LS_HU, 32'h103, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        drain();
        check32("fault_no_bus_beats", 32'(beats_seen - b0), 32'd0);
`endif

        // Reset while BEAT0 waits for ack, then a late ack
        bus_auto = 1'b0;
        issue(1'b0, LS_W, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, -1);
        @(negedge clk);
        check32("rst_pre_mem_req", {31'h0, mem_req}, 32'h1);
        check32("rst_pre_mem_addr", mem_addr, 32'h100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check32("rst_drops_mem_req", {31'h0, mem_req}, 32'h0);
        check32("rst_ready_low", {31'h0, req_ready}, 32'h0);
        rst = 1'b0;
        force_ack = 1'b1;
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        check32("late_ack_mem_req", {31'h0, mem_req}, 32'h0);
        check32("ready_after_rst", {31'h0, req_ready}, 32'h1);
        repeat (3) @(negedge clk);
        check32("no_rsp_after_rst", {31'h0, rsp_valid}, 32'h0);
        bus_auto = 1'b1;

        // Unit still operates after the abort
        mem[32'h200] = 32'hCAFEF00D;
        push_beat(32'h200, 4'b1111, 1'b0, 32'h0);
        issue(1'b0, LS_W, 32'h200, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 2);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
